decoder_scan_n: RTL and testbench

Registered, parametrised N-to-OUTS line decoder with 74LS138-style enable gating and active-low outputs, extended with an autonomous scan mode. In scan mode an internal prescaled counter walks the outputs for multiplexed digit or row selection. It sits between control logic and multiplexed display and keypad drivers, and replaces free-standing combinational decoders wherever a glitch-free, clock-aligned select is required.

---
 rtl/decoder_scan_n.sv | 112 +++++++++++
 tb/tb_decoder_scan_n.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/decoder_scan_n.sv
// Registered N-to-OUTS decoder with 74LS138-style enable gating, active-low
// select outputs, and an autonomous prescaled scan mode for multiplexed drivers.
module decoder_scan_n #(
    parameter int N    = 3,
    parameter int OUTS = 2**N,
    parameter int DIV  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    A,
    input  logic            G1,
    input  logic            G2_n,
    input  logic            G3_n,
    input  logic            mode,
    input  logic            hold,
    output logic [OUTS-1:0] Y,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_idx;
    logic [N-1:0]    w_idx_nxt;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_nxt;
    logic [OUTS-1:0] r_y;
    logic [OUTS-1:0] w_y_nxt;
    logic            r_wrap;
    logic            w_wrap_nxt;
    logic            w_en;
    logic            w_step;
    logic            w_a_ok;
    logic            w_presc_end;
    logic            w_idx_last;

    // Active-low one-hot select; indices at or above OUTS decode to all ones.
    function automatic logic [OUTS-1:0] decode(input logic [N-1:0] sel, input logic en);
        logic [OUTS-1:0] y;
        y = '1;
        for (int k = 0; k < OUTS; k++) begin
            if (en && (int'(sel) == k)) begin
                y[k] = 1'b0;
            end
        end
        return y;
    endfunction

    assign w_en        = G1 & ~G2_n & ~G3_n;
    assign w_step      = w_en & ~hold;
    assign w_a_ok      = (int'(A) < OUTS);
    assign w_presc_end = (int'(r_presc) == DIV - 1);
    assign w_idx_last  = (int'(r_idx) == OUTS - 1);

    always_comb begin
        w_state_nxt = mode ? ST_SCAN : ST_DIRECT;
        w_idx_nxt   = r_idx;
        w_presc_nxt = r_presc;
        w_wrap_nxt  = 1'b0;

        if (!mode) begin
            w_idx_nxt   = A;
            w_presc_nxt = '0;
        end else if (r_state == ST_DIRECT) begin
            // Scan entry: an out-of-range start index falls back to 0.
            w_idx_nxt   = w_a_ok ? A : '0;
            w_presc_nxt = '0;
        end else if (w_step) begin
            if (w_presc_end) begin
                w_presc_nxt = '0;
                if (w_idx_last) begin
                    w_idx_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end else begin
                w_presc_nxt = r_presc + 1'b1;
            end
        end

        w_y_nxt = decode(w_idx_nxt, w_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_DIRECT;
            r_idx   <= '0;
            r_presc <= '0;
            r_y     <= '1;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_presc <= w_presc_nxt;
            r_y     <= w_y_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign Y    = r_y;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n: a full 8-output DIV=4 instance and a
// truncated 6-output DIV=1 instance driven from shared inputs.
module tb_decoder_scan_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] A;
    logic       G1, G2_n, G3_n, mode, hold;

    logic [7:0] Y8;
    logic [2:0] idx8;
    logic       wrap8;
    logic [5:0] Y6;
    logic [2:0] idx6;
    logic       wrap6;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_dir [0:7] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [5:0] exp_six [0:5] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

    always #5 clk = ~clk;

    decoder_scan_n #(.N(3), .OUTS(8), .DIV(4)) u8 (
        .clk(clk), .rst(rst), .A(A), .G1(G1), .G2_n(G2_n), .G3_n(G3_n),
        .mode(mode), .hold(hold), .Y(Y8), .idx(idx8), .wrap(wrap8)
    );

    decoder_scan_n #(.N(3), .OUTS(6), .DIV(1)) u6 (
        .clk(clk), .rst(rst), .A(A), .G1(G1), .G2_n(G2_n), .G3_n(G3_n),
        .mode(mode), .hold(hold), .Y(Y6), .idx(idx6), .wrap(wrap6)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] y, input logic [2:0] i, input logic w);
        chk({tag, ".Y"}, 64'(Y8), 64'(y));
        chk({tag, ".idx"}, 64'(idx8), 64'(i));
        chk({tag, ".wrap"}, 64'(wrap8), 64'(w));
    endtask

    task automatic chk6(input string tag, input logic [5:0] y, input logic [2:0] i, input logic w);
        chk({tag, ".Y"}, 64'(Y6), 64'(y));
        chk({tag, ".idx"}, 64'(idx6), 64'(i));
        chk({tag, ".wrap"}, 64'(wrap6), 64'(w));
    endtask

    initial begin
        rst = 1'b1; A = 3'd0; G1 = 1'b0; G2_n = 1'b1; G3_n = 1'b1;
        mode = 1'b0; hold = 1'b0;

        // reset state
        tick();
        tick();
        chk8("reset8", 8'hFF, 3'd0, 1'b0);
        chk6("reset6", 6'h3F, 3'd0, 1'b0);
        rst = 1'b0;

        // gating: disabled combinations
        {G1, G2_n, G3_n} = 3'b000; tick(); chk8("gate000", 8'hFF, 3'd0, 1'b0);
        {G1, G2_n, G3_n} = 3'b110; tick(); chk8("gate110", 8'hFF, 3'd0, 1'b0);
        {G1, G2_n, G3_n} = 3'b101; tick(); chk8("gate101", 8'hFF, 3'd0, 1'b0);

        // enabled direct decode, A held for two cycles each
        {G1, G2_n, G3_n} = 3'b100;
        for (int a = 0; a < 8; a++) begin
            A = 3'(a);
            tick();
            chk8("direct", exp_dir[a], 3'(a), 1'b0);
            tick();
            chk8("direct_hold", exp_dir[a], 3'(a), 1'b0);
            if (a >= 6) chk6("trunc_direct", 6'h3F, 3'(a), 1'b0);
        end

        // scan wrap from start index 6
        A = 3'd6; tick(); chk8("pre_scan", 8'hBF, 3'd6, 1'b0);
        mode = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin chk8("scan_i6", 8'hBF, 3'd6, 1'b0); tick(); end
        for (int k = 0; k < 4; k++) begin chk8("scan_i7", 8'h7F, 3'd7, 1'b0); tick(); end
        chk8("scan_wrap", 8'hFE, 3'd0, 1'b1);
        tick();
        chk8("scan_after_wrap", 8'hFE, 3'd0, 1'b0);

        // hold two cycles, then disable three cycles; presc sits at 1
        hold = 1'b1;
        tick(); chk8("hold1", 8'hFE, 3'd0, 1'b0);
        tick(); chk8("hold2", 8'hFE, 3'd0, 1'b0);
        hold = 1'b0; G1 = 1'b0;
        for (int k = 0; k < 3; k++) begin tick(); chk8("disabled", 8'hFF, 3'd0, 1'b0); end
        G1 = 1'b1;
        tick(); chk8("resume_p2", 8'hFE, 3'd0, 1'b0);
        tick(); chk8("resume_p3", 8'hFE, 3'd0, 1'b0);
        tick(); chk8("resume_step", 8'hFD, 3'd1, 1'b0);

        // advance to idx=5, presc=2, then async reset between edges
        repeat (18) tick();
        chk8("pre_reset", 8'hDF, 3'd5, 1'b0);
        #2 rst = 1'b1;
        #1 chk8("async_reset", 8'hFF, 3'd0, 1'b0);
        #2 rst = 1'b0;
        A = 3'd3;
        tick(); chk8("reentry", 8'hF7, 3'd3, 1'b0);
        tick(); chk8("reentry_hold", 8'hF7, 3'd3, 1'b0);

        // truncated decoder: direct out-of-range, then scan entry from A=7
        mode = 1'b0; A = 3'd6;
        tick();
        chk6("trunc_dir6", 6'h3F, 3'd6, 1'b0);
        chk8("full_dir6", 8'hBF, 3'd6, 1'b0);
        mode = 1'b1; A = 3'd7;
        tick();
        chk6("trunc_entry", 6'h3E, 3'd0, 1'b0);
        chk8("full_entry7", 8'h7F, 3'd7, 1'b0);
        for (int f = 0; f < 2; f++) begin
            for (int k = 1; k < 6; k++) begin
                tick();
                chk6("trunc_scan", exp_six[k], 3'(k), 1'b0);
            end
            tick();
            chk6("trunc_wrap", 6'h3E, 3'd0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
